// File: rtl/mips_debug_unit_if.sv
// Debug-unit bus: UART byte streams plus the core's instruction-write and debug-read ports.
// The master side is the debug unit; the slave side is the UART/core environment.
interface mips_debug_unit_if #(
    parameter int N_BITS = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done;
    logic [N_BITS-1:0] out_addr_mem_inst;
    logic [N_BITS-1:0] out_ins_to_mem;
    logic              out_wea_ram_inst;
    logic              out_core_enable;
    logic [N_BITS-1:0] out_addr_debug;
    logic              out_debug_sel_mem;
    logic [N_BITS-1:0] in_debug_data;
    logic [N_BITS-1:0] in_pc;
    logic              in_halt;

    modport master (
        input  rx_data, rx_valid, tx_done, in_debug_data, in_pc, in_halt,
        output tx_data, tx_start, out_addr_mem_inst, out_ins_to_mem,
               out_wea_ram_inst, out_core_enable, out_addr_debug, out_debug_sel_mem
    );

    modport slave (
        output rx_data, rx_valid, tx_done, in_debug_data, in_pc, in_halt,
        input  tx_data, tx_start, out_addr_mem_inst, out_ins_to_mem,
               out_wea_ram_inst, out_core_enable, out_addr_debug, out_debug_sel_mem
    );
endinterface

// File: rtl/mips_debug_unit.sv
// Host-side debug controller: loads instruction memory from UART bytes, runs or steps the
// core, then streams PC, register file and data memory back out byte by byte.
module mips_debug_unit #(
    parameter int N_BITS      = 32,
    parameter int N_INSTR_MAX = 64,
    parameter int N_REGS      = 32,
    parameter int N_MEM       = 16
) (
    input  logic               clk,
    input  logic               reset,
    mips_debug_unit_if.master  bus
);
    localparam int M  = 1 + N_REGS + N_MEM;
    localparam int WW = $clog2(M);
    localparam logic [WW-1:0] LAST_W = WW'(M - 1);
    localparam logic [WW-1:0] REGS_W = WW'(N_REGS);

    typedef enum logic [3:0] {
        IDLE, LOAD_COUNT, LOAD_BYTES, LOAD_WRITE, RUN, STEP,
        DUMP_SEL, DUMP_LAT, DUMP_SEND, DUMP_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        k_q, k_d;
    logic [1:0]        byte_q, byte_d;
    logic [N_BITS-1:0] word_q, word_d;
    logic [WW-1:0]     widx_q, widx_d;
    logic [WW-1:0]     reg_idx, mem_idx;

    // word_q doubles as the load assembly register and the dump transmit shifter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            k_q     <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            k_q     <= k_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            widx_q  <= widx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        k_d     = k_q;
        byte_d  = byte_q;
        word_d  = word_q;
        widx_d  = widx_q;
        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        8'h01:   state_d = LOAD_COUNT;
                        8'h02:   state_d = RUN;
                        8'h03:   state_d = STEP;
                        default: state_d = IDLE;
                    endcase
                end
            end
            LOAD_COUNT: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == 8'h00) begin
                        state_d = IDLE;
                    end else begin
                        count_d = bus.rx_data;
                        k_d     = '0;
                        byte_d  = '0;
                        state_d = LOAD_BYTES;
                    end
                end
            end
            LOAD_BYTES: begin
                if (bus.rx_valid) begin
                    word_d = {word_q[N_BITS-9:0], bus.rx_data};
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) state_d = LOAD_WRITE;
                end
            end
            LOAD_WRITE: begin
                k_d     = k_q + 8'd1;
                state_d = (k_q + 8'd1 == count_q) ? IDLE : LOAD_BYTES;
            end
            RUN: begin
                if (bus.in_halt) begin
                    widx_d  = '0;
                    byte_d  = '0;
                    state_d = DUMP_SEL;
                end
            end
            STEP: begin
                widx_d  = '0;
                byte_d  = '0;
                state_d = DUMP_SEL;
            end
            DUMP_SEL: begin
                // Word 0 is the PC, taken directly without a debug-port read
                if (widx_q == '0) begin
                    word_d  = bus.in_pc;
                    state_d = DUMP_SEND;
                end else begin
                    state_d = DUMP_LAT;
                end
            end
            DUMP_LAT: begin
                word_d  = bus.in_debug_data;
                state_d = DUMP_SEND;
            end
            DUMP_SEND: state_d = DUMP_WAIT;
            DUMP_WAIT: begin
                if (bus.tx_done) begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q != 2'd3) begin
                        word_d  = word_q << 8;
                        state_d = DUMP_SEND;
                    end else if (widx_q == LAST_W) begin
                        widx_d  = '0;
                        state_d = IDLE;
                    end else begin
                        widx_d  = widx_q + WW'(1);
                        state_d = DUMP_SEL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign reg_idx = widx_q - WW'(1);
    assign mem_idx = widx_q - WW'(N_REGS + 1);

    always_comb begin
        bus.tx_data           = '0;
        bus.tx_start          = 1'b0;
        bus.out_addr_mem_inst = '0;
        bus.out_ins_to_mem    = '0;
        bus.out_wea_ram_inst  = 1'b0;
        bus.out_core_enable   = 1'b0;
        bus.out_addr_debug    = '0;
        bus.out_debug_sel_mem = 1'b0;
        case (state_q)
            LOAD_WRITE: begin
                bus.out_wea_ram_inst  = (int'(k_q) < N_INSTR_MAX);
                bus.out_addr_mem_inst = N_BITS'({k_q, 2'b00});
                bus.out_ins_to_mem    = word_q;
            end
            RUN, STEP: bus.out_core_enable = !bus.in_halt;
            DUMP_SEL, DUMP_LAT, DUMP_SEND, DUMP_WAIT: begin
                if (widx_q == '0) begin
                    bus.out_addr_debug = '0;
                end else if (widx_q <= REGS_W) begin
                    bus.out_addr_debug = N_BITS'(reg_idx);
                end else begin
                    bus.out_addr_debug    = N_BITS'(mem_idx);
                    bus.out_debug_sel_mem = 1'b1;
                end
                if (state_q == DUMP_SEND) begin
                    bus.tx_start = 1'b1;
                    bus.tx_data  = word_q[N_BITS-1 -: 8];
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_debug_unit.sv
// Directed bench for mips_debug_unit: UART responder, core/debug-port model, scenario tasks.
module tb_mips_debug_unit;
    localparam int NB         = 32;
    localparam int DUMP_BYTES = 4 * (1 + 32 + 16);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_debug_unit_if #(.N_BITS(NB)) bus();

    mips_debug_unit #(.N_BITS(NB), .N_INSTR_MAX(64), .N_REGS(32), .N_MEM(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmode    = 1'b0;
    logic [31:0] dbg_q;
    logic [7:0]  tx_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int en_cnt   = 0;
    int gate_err = 0;
    bit busy     = 1'b0;

    // Debug read port: registered, one cycle after the select; distinct value per address
    always @(posedge clk)
        dbg_q <= bus.out_debug_sel_mem ? (32'hD000_0000 | bus.out_addr_debug)
                                       : (32'hC000_0000 | bus.out_addr_debug);
    assign bus.in_debug_data = cmode ? 32'hA5A5_A5A5 : dbg_q;

    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                tx_q.push_back(bus.tx_data);
                repeat (3) @(posedge clk);
                #1 bus.tx_done = 1'b1;
                @(posedge clk);
                #1 bus.tx_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.out_core_enable === 1'b1) en_cnt++;
        if (bus.out_wea_ram_inst === 1'b1) begin
            wr_addr_q.push_back(bus.out_addr_mem_inst);
            wr_data_q.push_back(bus.out_ins_to_mem);
        end
    end

    always @(negedge clk) begin
        if (!reset) busy = 1'b0;
        else begin
            if (bus.tx_done === 1'b1) busy = 1'b0;
            if (bus.tx_start === 1'b1) begin
                if (busy) gate_err++;
                busy = 1'b1;
            end
        end
    end

    function automatic logic [7:0] exp_byte(int i, logic [31:0] pc, bit cm);
        int w;
        logic [31:0] word;
        w = i / 4;
        if (w == 0)       word = pc;
        else if (cm)      word = 32'hA5A5_A5A5;
        else if (w <= 32) word = 32'hC000_0000 | 32'(w - 1);
        else              word = 32'hD000_0000 | 32'(w - 33);
        return word[31 - 8*(i%4) -: 8];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_dump(input int b0, output bit ok);
        int g;
        g = 0;
        while (tx_q.size() < b0 + DUMP_BYTES && g < 5000) begin
            @(posedge clk);
            g++;
        end
        ok = (tx_q.size() >= b0 + DUMP_BYTES);
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.tx_start !== 1'b0) $display("FAIL reset_tx_start: got %0b want 0", bus.tx_start); else n_pass++;
        n_checks++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); else n_pass++;
        n_checks++; if (bus.out_wea_ram_inst !== 1'b0) $display("FAIL reset_wea: got %0b want 0", bus.out_wea_ram_inst); else n_pass++;
        n_checks++; if (bus.out_core_enable !== 1'b0) $display("FAIL reset_enable: got %0b want 0", bus.out_core_enable); else n_pass++;
        n_checks++; if (bus.out_addr_debug !== 32'h0) $display("FAIL reset_addr_debug: got %h want 0", bus.out_addr_debug); else n_pass++;
        n_checks++; if (bus.out_addr_mem_inst !== 32'h0) $display("FAIL reset_addr_mem: got %h want 0", bus.out_addr_mem_inst); else n_pass++;
        reset = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_load();
        int w0, e0, b0;
        logic [7:0] bytes [8];
        bytes = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07};
        w0 = wr_addr_q.size();
        send_byte(8'h01);
        send_byte(8'h02);
        for (int i = 0; i < 8; i++) send_byte(bytes[i]);
        repeat (4) @(posedge clk);
        n_checks++; if (wr_addr_q.size() - w0 !== 2) $display("FAIL load_pulses: got %0d want 2", wr_addr_q.size() - w0); else n_pass++;
        if (wr_addr_q.size() - w0 >= 2) begin
            n_checks++; if (wr_addr_q[w0] !== 32'h0) $display("FAIL load_addr0: got %h want 0", wr_addr_q[w0]); else n_pass++;
            n_checks++; if (wr_data_q[w0] !== 32'h2001_0005) $display("FAIL load_data0: got %h want 20010005", wr_data_q[w0]); else n_pass++;
            n_checks++; if (wr_addr_q[w0+1] !== 32'h4) $display("FAIL load_addr1: got %h want 4", wr_addr_q[w0+1]); else n_pass++;
            n_checks++; if (wr_data_q[w0+1] !== 32'h2002_0007) $display("FAIL load_data1: got %h want 20020007", wr_data_q[w0+1]); else n_pass++;
        end
        // Back in IDLE an unknown command byte must have no effect
        e0 = en_cnt; b0 = tx_q.size(); w0 = wr_addr_q.size();
        send_byte(8'h07);
        repeat (10) @(posedge clk);
        n_checks++; if (en_cnt - e0 !== 0) $display("FAIL junk_enable: got %0d want 0", en_cnt - e0); else n_pass++;
        n_checks++; if (tx_q.size() - b0 !== 0) $display("FAIL junk_tx: got %0d want 0", tx_q.size() - b0); else n_pass++;
        n_checks++; if (wr_addr_q.size() - w0 !== 0) $display("FAIL junk_write: got %0d want 0", wr_addr_q.size() - w0); else n_pass++;
    endtask

    task automatic test_load_zero_step();
        int w0, e0, b0, bad, first_bad;
        bit ok;
        cmode = 1'b0;
        bus.in_pc = 32'h0000_0040;
        w0 = wr_addr_q.size(); e0 = en_cnt; b0 = tx_q.size();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h03);
        wait_dump(b0, ok);
        n_checks++; if (wr_addr_q.size() - w0 !== 0) $display("FAIL zero_load_writes: got %0d want 0", wr_addr_q.size() - w0); else n_pass++;
        n_checks++; if (en_cnt - e0 !== 1) $display("FAIL step_enable_cycles: got %0d want 1", en_cnt - e0); else n_pass++;
        n_checks++; if (tx_q.size() - b0 !== DUMP_BYTES) $display("FAIL step_dump_len: got %0d want %0d", tx_q.size() - b0, DUMP_BYTES); else n_pass++;
        bad = 0; first_bad = -1;
        for (int i = 0; i < DUMP_BYTES && b0 + i < tx_q.size(); i++)
            if (tx_q[b0+i] !== exp_byte(i, 32'h40, 1'b0)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        n_checks++; if (bad !== 0) $display("FAIL step_dump_data: %0d bad bytes, first at %0d want 0 bad", bad, first_bad); else n_pass++;
    endtask

    task automatic test_run();
        int e0, b0, g0, guard, bad;
        bit ok;
        cmode = 1'b1;
        bus.in_pc   = 32'h0000_0028;
        bus.in_halt = 1'b0;
        e0 = en_cnt; b0 = tx_q.size(); g0 = gate_err;
        send_byte(8'h02);
        guard = 0;
        while (en_cnt - e0 < 10 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        #1 bus.in_halt = 1'b1;
        wait_dump(b0, ok);
        n_checks++; if (en_cnt - e0 !== 10) $display("FAIL run_enable_cycles: got %0d want 10", en_cnt - e0); else n_pass++;
        n_checks++; if (tx_q.size() - b0 !== DUMP_BYTES) $display("FAIL run_dump_len: got %0d want %0d", tx_q.size() - b0, DUMP_BYTES); else n_pass++;
        if (tx_q.size() - b0 >= 4) begin
            n_checks++;
            if ({tx_q[b0], tx_q[b0+1], tx_q[b0+2], tx_q[b0+3]} !== 32'h0000_0028)
                $display("FAIL run_pc_bytes: got %h%h%h%h want 00000028", tx_q[b0], tx_q[b0+1], tx_q[b0+2], tx_q[b0+3]);
            else n_pass++;
        end
        bad = 0;
        for (int i = 4; i < DUMP_BYTES && b0 + i < tx_q.size(); i++)
            if (tx_q[b0+i] !== 8'hA5) bad++;
        n_checks++; if (bad !== 0) $display("FAIL run_dump_data: %0d bytes not A5, want 0", bad); else n_pass++;
        n_checks++; if (gate_err - g0 !== 0) $display("FAIL tx_gating: %0d starts before done, want 0", gate_err - g0); else n_pass++;
        bus.in_halt = 1'b0;
        cmode = 1'b0;
    endtask

    task automatic test_run_halted();
        int e0, b0;
        bit ok;
        cmode = 1'b1;
        bus.in_halt = 1'b1;
        e0 = en_cnt; b0 = tx_q.size();
        send_byte(8'h02);
        wait_dump(b0, ok);
        n_checks++; if (en_cnt - e0 !== 0) $display("FAIL halted_enable: got %0d want 0", en_cnt - e0); else n_pass++;
        n_checks++; if (tx_q.size() - b0 !== DUMP_BYTES) $display("FAIL halted_dump_len: got %0d want %0d", tx_q.size() - b0, DUMP_BYTES); else n_pass++;
        bus.in_halt = 1'b0;
        cmode = 1'b0;
    endtask

    task automatic test_load_overflow();
        int w0, e0, b0, n;
        bit ok;
        w0 = wr_addr_q.size();
        send_byte(8'h01);
        send_byte(8'd70);
        for (int i = 0; i < 280; i++) send_byte(8'(i));
        repeat (4) @(posedge clk);
        n = wr_addr_q.size() - w0;
        n_checks++; if (n !== 64) $display("FAIL ovf_pulses: got %0d want 64", n); else n_pass++;
        if (n >= 2) begin
            n_checks++; if (wr_data_q[w0+1] !== 32'h0405_0607) $display("FAIL ovf_data1: got %h want 04050607", wr_data_q[w0+1]); else n_pass++;
            n_checks++; if (wr_addr_q[w0+n-1] !== 32'hFC) $display("FAIL ovf_last_addr: got %h want fc", wr_addr_q[w0+n-1]); else n_pass++;
            n_checks++; if (wr_data_q[w0+n-1] !== 32'hFCFD_FEFF) $display("FAIL ovf_last_data: got %h want fcfdfeff", wr_data_q[w0+n-1]); else n_pass++;
        end
        e0 = en_cnt; b0 = tx_q.size();
        send_byte(8'h03);
        wait_dump(b0, ok);
        n_checks++; if (en_cnt - e0 !== 1) $display("FAIL ovf_next_cmd_step: got %0d enable cycles want 1", en_cnt - e0); else n_pass++;
    endtask

    task automatic test_reset_mid_dump();
        int b0, guard, bad;
        bit ok;
        cmode = 1'b0;
        bus.in_pc = 32'h0000_0100;
        b0 = tx_q.size();
        send_byte(8'h03);
        guard = 0;
        while (tx_q.size() < b0 + 5 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        #1 reset = 1'b0;
        #1;
        n_checks++; if (bus.tx_start !== 1'b0) $display("FAIL mid_reset_tx_start: got %0b want 0", bus.tx_start); else n_pass++;
        n_checks++; if (bus.out_addr_debug !== 32'h0) $display("FAIL mid_reset_addr_debug: got %h want 0", bus.out_addr_debug); else n_pass++;
        n_checks++; if (bus.out_debug_sel_mem !== 1'b0) $display("FAIL mid_reset_sel: got %0b want 0", bus.out_debug_sel_mem); else n_pass++;
        n_checks++; if (bus.out_core_enable !== 1'b0) $display("FAIL mid_reset_enable: got %0b want 0", bus.out_core_enable); else n_pass++;
        repeat (5) @(posedge clk);
        n_checks++; if (tx_q.size() - b0 !== 5) $display("FAIL mid_reset_bytes: got %0d want 5", tx_q.size() - b0); else n_pass++;
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        b0 = tx_q.size();
        send_byte(8'h03);
        wait_dump(b0, ok);
        n_checks++; if (tx_q.size() - b0 !== DUMP_BYTES) $display("FAIL post_reset_dump_len: got %0d want %0d", tx_q.size() - b0, DUMP_BYTES); else n_pass++;
        bad = 0;
        for (int i = 0; i < DUMP_BYTES && b0 + i < tx_q.size(); i++)
            if (tx_q[b0+i] !== exp_byte(i, 32'h100, 1'b0)) bad++;
        n_checks++; if (bad !== 0) $display("FAIL post_reset_dump_data: %0d bad bytes want 0", bad); else n_pass++;
    endtask

    initial begin
        reset        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.in_pc    = 32'h0;
        bus.in_halt  = 1'b0;
        test_reset();
        test_load();
        test_load_zero_step();
        test_run();
        test_run_halted();
        test_load_overflow();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mips_debug_unit.md
Name: mips_debug_unit

Overview:
- Host-side controller for the MIPS core's debug interface.
- Receives commands as a byte stream from a UART receiver and loads the instruction memory through the core's write port.
- Runs the core continuously, or steps it one cycle at a time.
- When the core halts or a step ends, reads back PC, registers and data memory through the core's debug address port and streams them to a UART transmitter.

Parameters:
- N_BITS, 32, data/address word width.
- N_INSTR_MAX, 64, maximum instructions accepted per LOAD.
- N_REGS, 32, registers dumped.
- N_MEM, 16, data-memory words dumped.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  output  8  byte to transmit.
- tx_start  output  1  one-cycle strobe to the transmitter.
- tx_done  input  1  one-cycle strobe; transmitter has finished the byte.
- out_addr_mem_inst  output  N_BITS  instruction-memory byte address.
- out_ins_to_mem  output  N_BITS  instruction word to write.
- out_wea_ram_inst  output  1  instruction-memory write enable.
- out_core_enable  output  1  core advances one cycle per clk while high.
- out_addr_debug  output  N_BITS  debug read select: register index, or data-memory word index.
- out_debug_sel_mem  output  1  0 = register file, 1 = data memory.
- in_debug_data  input  N_BITS  word selected by out_addr_debug/out_debug_sel_mem; valid one cycle after the select.
- in_pc  input  N_BITS  current PC.
- in_halt  input  1  core has halted.

Behaviour:
- Reset (async, active-low): state IDLE; every output 0; internal counters 0.
- Commands are accepted only in IDLE; rx_valid is ignored in every other state except LOAD_*.
  - 0x01 = LOAD, 0x02 = RUN, 0x03 = STEP.
  - Any other byte is discarded and the state stays IDLE.
- LOAD_COUNT: next byte is N.
  - N = 0: return to IDLE.
  - Otherwise go to LOAD_BYTES with k = 0.
- LOAD_BYTES: 4 bytes per word, MSB first, shifted into a word register.
  - One clk after the 4th byte, write cycle: out_wea_ram_inst = 1 for exactly 1 cycle, out_addr_mem_inst = 4*k, out_ins_to_mem = the assembled word.
  - k increments after the write.
  - When k reaches N, return to IDLE and drop write enable.
  - If N > N_INSTR_MAX, all 4N bytes are still consumed but writes with k >= N_INSTR_MAX are suppressed (no enable pulse).
- RUN: if in_halt is already 1, go straight to DUMP with out_core_enable held 0. Otherwise out_core_enable = 1 from the cycle after the command byte; it falls to 0 combinationally with in_halt, the same cycle, then DUMP.
- STEP: out_core_enable = 1 for exactly one clk cycle (0 if in_halt), then DUMP.
- DUMP sequence: M = 1 + N_REGS + N_MEM words.
  - Word 0 is in_pc, sampled on entry to DUMP.
  - Words 1..N_REGS: registers 0..N_REGS-1, out_debug_sel_mem = 0.
  - Remaining words: memory words 0..N_MEM-1, out_debug_sel_mem = 1.
  - For each register/memory word: drive out_addr_debug and out_debug_sel_mem (SEL), wait 1 cycle (LAT), capture in_debug_data into the tx shift register.
  - Each word is sent as 4 bytes, MSB first.
  - Per byte: tx_data set and tx_start = 1 for one cycle, then wait for tx_done before the next byte.
  - tx_done arriving in the same cycle as tx_start is ignored.
  - After the last byte's tx_done, out_addr_debug and out_debug_sel_mem return to 0 and the state returns to IDLE.
- States: IDLE, LOAD_COUNT, LOAD_BYTES, LOAD_WRITE, RUN, STEP, DUMP_SEL, DUMP_LAT, DUMP_SEND, DUMP_WAIT.
- rx_valid in RUN, STEP or DUMP_*: the byte is dropped, not queued.
- Reset mid-LOAD or mid-DUMP: immediate return to IDLE, all strobes 0, partial word discarded.

Test Plan:
- LOAD, N=2, bytes 0x20 0x01 0x00 0x05 0x20 0x02 0x00 0x07 -> two single-cycle write pulses: addr 0x0 data 0x20010005, then addr 0x4 data 0x20020007; state then IDLE.
- LOAD N=0, then byte 0x03 -> no write pulse; 0x03 is taken as STEP (one enable cycle followed by a dump).
- RUN with in_halt rising after 10 cycles, in_pc = 0x28, all debug data = 0xA5A5A5A5 -> out_core_enable high exactly 10 cycles; first 4 tx bytes 0x00 0x00 0x00 0x28; total tx_start pulses 4*(1+32+16) = 196, each gated by tx_done.
- RUN with in_halt already 1 -> out_core_enable never asserted; dump begins.
- LOAD N=70 (N_INSTR_MAX = 64) with 280 bytes -> exactly 64 write pulses, last at addr 0xFC; next byte is interpreted as a command.
- reset low during dump byte 5 -> tx_start stops, all outputs 0; a subsequent STEP gives a full 196-byte dump starting from the PC.
